// File: rtl/ce_pkg.sv
// Shared decode constants, filter FSM states and the function-match helper for the CE RX path.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package ce_pkg;

    localparam int HDR_W         = 256;
    localparam int PF_NUM_LSB    = 160;
    localparam int PF_NUM_W      = 3;
    localparam int VF_NUM_LSB    = 163;
    localparam int VF_NUM_W      = 11;
    localparam int VF_ACTIVE_BIT = 174;

    typedef enum logic [1:0] {
        SOP  = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } t_flt_state;

    // VF mode matches on vf_active=1 and vf_num; PF mode requires vf_active=0 and pf_num.
    function automatic logic func_match(
        input logic [HDR_W-1:0]    hdr,
        input logic [PF_NUM_W-1:0] pf,
        input logic [VF_NUM_W-1:0] vf,
        input logic                vfa
    );
        logic                hdr_vfa;
        logic [PF_NUM_W-1:0] hdr_pf;
        logic [VF_NUM_W-1:0] hdr_vf;
        hdr_vfa = hdr[VF_ACTIVE_BIT];
        hdr_pf  = hdr[PF_NUM_LSB +: PF_NUM_W];
        hdr_vf  = hdr[VF_NUM_LSB +: VF_NUM_W];
        if (vfa) begin
            return hdr_vfa && (hdr_vf == vf);
        end
        return !hdr_vfa && (hdr_pf == pf);
    endfunction

endpackage

// File: rtl/ce_axis_skid_buf.sv
// Generic 2-entry registered skid buffer; entry 0 drives the output directly.
// Latency: 1 cycle from accepted input to out_vld when empty; 1 beat/cycle sustained.
// Backpressure: in_rdy is registered and drops only when both entries are occupied.
module ce_axis_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    logic [1:0]   cnt_q;
    logic [1:0]   cnt_nxt;
    logic [W-1:0] e0_q;
    logic [W-1:0] e1_q;
    logic         rdy_q;
    logic         push;
    logic         pop;

    assign push    = in_vld && rdy_q;
    assign pop     = (cnt_q != 2'd0) && out_rdy;
    assign in_rdy  = rdy_q;
    assign out_vld = (cnt_q != 2'd0);
    assign out_dat = e0_q;

    always_comb begin
        cnt_nxt = cnt_q + 2'(push) - 2'(pop);
    end

    // Push with pop at one entry refills the head directly, so occupancy stays 1 with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            rdy_q <= 1'b0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_nxt;
            rdy_q <= (cnt_nxt != 2'd2);
            if (push && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop))) begin
                e0_q <= in_dat;
            end else if (pop && (cnt_q == 2'd2)) begin
                e0_q <= e1_q;
            end
            if (push && (cnt_q == 2'd1) && !pop) begin
                e1_q <= in_dat;
            end
        end
    end

endmodule

// File: rtl/ce_rx_func_filter.sv
// Packet-aware AXI-S filter: forwards TLPs addressed to the CE function, drains all others.
// Latency: 1 cycle through the output skid; Stats counters built only with CE_RX_FILTER_STATS_EN.
// Backpressure: rx_tready is the registered skid not-full; dropped beats also wait on it.
module ce_rx_func_filter
    import ce_pkg::*;
#(
    parameter int CE_PF_ID     = 4,
    parameter int CE_VF_ID     = 0,
    parameter int CE_VF_ACTIVE = 0,
    parameter int DATA_W       = 512,
    parameter int USER_W       = 10,
    parameter int CNT_W        = 32
) (
    input  logic                fim_clk,
    input  logic                fim_rst_n,
    input  logic                rx_tvalid,
    output logic                rx_tready,
    input  logic [DATA_W-1:0]   rx_tdata,
    input  logic [DATA_W/8-1:0] rx_tkeep,
    input  logic                rx_tlast,
    input  logic [USER_W-1:0]   rx_tuser,
    output logic                ce_tvalid,
    input  logic                ce_tready,
    output logic [DATA_W-1:0]   ce_tdata,
    output logic [DATA_W/8-1:0] ce_tkeep,
    output logic                ce_tlast,
    output logic [USER_W-1:0]   ce_tuser,
    output logic [CNT_W-1:0]    pass_cnt,
    output logic [CNT_W-1:0]    drop_cnt
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int PLD_W  = DATA_W + KEEP_W + 1 + USER_W;

    t_flt_state       state_q;
    t_flt_state       state_nxt;
    logic             accept;
    logic             hit;
    logic             fwd;
    logic [PLD_W-1:0] pld_in;
    logic [PLD_W-1:0] pld_out;

    assign accept = rx_tvalid && rx_tready;
    assign hit    = func_match(rx_tdata[HDR_W-1:0], PF_NUM_W'(CE_PF_ID),
                               VF_NUM_W'(CE_VF_ID), (CE_VF_ACTIVE != 0));

    // The header is decoded only in SOP; later beats follow the SOP verdict untouched.
    always_comb begin
        state_nxt = state_q;
        fwd       = 1'b0;
        case (state_q)
            SOP: begin
                if (accept) begin
                    fwd = hit;
                    if (!rx_tlast) begin
                        state_nxt = hit ? PASS : DROP;
                    end
                end
            end
            PASS: begin
                fwd = accept;
                if (accept && rx_tlast) begin
                    state_nxt = SOP;
                end
            end
            DROP: begin
                if (accept && rx_tlast) begin
                    state_nxt = SOP;
                end
            end
            default: state_nxt = SOP;
        endcase
    end

    always_ff @(posedge fim_clk or negedge fim_rst_n) begin
        if (!fim_rst_n) begin
            state_q <= SOP;
        end else begin
            state_q <= state_nxt;
        end
    end

    assign pld_in = {rx_tuser, rx_tlast, rx_tkeep, rx_tdata};
    assign {ce_tuser, ce_tlast, ce_tkeep, ce_tdata} = pld_out;

    ce_axis_skid_buf #(
        .W (PLD_W)
    ) u_skid (
        .clk     (fim_clk),
        .rst_n   (fim_rst_n),
        .in_vld  (fwd),
        .in_rdy  (rx_tready),
        .in_dat  (pld_in),
        .out_vld (ce_tvalid),
        .out_rdy (ce_tready),
        .out_dat (pld_out)
    );

`ifdef CE_RX_FILTER_STATS_EN
    logic [CNT_W-1:0] pass_q;
    logic [CNT_W-1:0] drop_q;

    // Counters saturate rather than wrap so a long run never reads back as a small value.
    always_ff @(posedge fim_clk or negedge fim_rst_n) begin
        if (!fim_rst_n) begin
            pass_q <= '0;
            drop_q <= '0;
        end else if (accept && rx_tlast) begin
            if (fwd) begin
                if (pass_q != {CNT_W{1'b1}}) begin
                    pass_q <= pass_q + CNT_W'(1);
                end
            end else begin
                if (drop_q != {CNT_W{1'b1}}) begin
                    drop_q <= drop_q + CNT_W'(1);
                end
            end
        end
    end

    assign pass_cnt = pass_q;
    assign drop_cnt = drop_q;
`else
    assign pass_cnt = '0;
    assign drop_cnt = '0;
`endif

endmodule
